// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD arbiter slice.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int GCD_W           = 8;
  localparam int GCD_TIMEOUT_CYC = 255;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; returns the first requesting
// index at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sharing of one GCD unit among NREQ requesters.
// Define GCD_TIMEOUT_EN to add a WAIT timeout counter and the TIMEOUT output.
//
// state | meaning
// IDLE  | no grant; arbitrate REQ, latch operands on grant
// ISSUE | pulse GCD_START
// WAIT  | wait for a GCD_DONE rising edge (or timeout)
// RESP  | pulse ACK[GNT_ID], advance round-robin pointer
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = GCD_W,
`ifdef GCD_TIMEOUT_EN
  parameter int TIMEOUT_CYC = GCD_TIMEOUT_CYC,
`endif
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ*W-1:0] OPA,
  input  logic [NREQ*W-1:0] OPB,
  output logic [NREQ-1:0] ACK,
  output logic [W-1:0]    RES_Y,
  output logic            RES_ERR,
  output logic            BUSY,
  output logic [IDW-1:0]  GNT_ID,
  output logic            GCD_START,
  output logic [W-1:0]    GCD_A,
  output logic [W-1:0]    GCD_B,
  input  logic [W-1:0]    GCD_Y,
  input  logic            GCD_ERROR,
`ifdef GCD_TIMEOUT_EN
  input  logic            GCD_DONE,
  output logic            TIMEOUT
`else
  input  logic            GCD_DONE
`endif
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, pick_idx;
  logic           pick_vld;
  logic           done_q, done_rise, to_hit;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req  (REQ),
    .ptr  (rr_ptr),
    .valid(pick_vld),
    .idx  (pick_idx)
  );

  // done_q resets high so a DONE held through reset is not taken as an edge.
  assign done_rise = GCD_DONE & ~done_q;

`ifdef GCD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_flag;

  // Loaded in ISSUE so terminal count lands the ACK TIMEOUT_CYC cycles after START.
  assign to_hit  = (state == WAIT) && !done_rise && (to_cnt == '0);
  assign TIMEOUT = (state == RESP) && to_flag;

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == ISSUE)                      to_cnt <= TW'(TIMEOUT_CYC - 2);
      else if (state == WAIT && to_cnt != '0)  to_cnt <= to_cnt - 1'b1;
      if (state == ISSUE)  to_flag <= 1'b0;
      else if (to_hit)     to_flag <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_rise || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ACK       = '0;
    if (state == RESP) ACK[GNT_ID] = 1'b1;
    BUSY      = (state != IDLE);
    GCD_START = (state == ISSUE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      GNT_ID  <= '0;
      GCD_A   <= '0;
      GCD_B   <= '0;
      RES_Y   <= '0;
      RES_ERR <= 1'b0;
      rr_ptr  <= '0;
      done_q  <= 1'b1;
    end else begin
      done_q <= GCD_DONE;
      if (state == IDLE && pick_vld) begin
        GNT_ID <= pick_idx;
        GCD_A  <= OPA[int'(pick_idx)*W +: W];
        GCD_B  <= OPB[int'(pick_idx)*W +: W];
      end
      if (state == WAIT) begin
        if (done_rise) begin
          RES_Y   <= GCD_Y;
          RES_ERR <= GCD_ERROR;
        end else if (to_hit) begin
          RES_Y   <= '0;
          RES_ERR <= 1'b1;
        end
      end
      if (state == RESP)
        rr_ptr <= (GNT_ID == IDW'(NREQ - 1)) ? '0 : GNT_ID + 1'b1;
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural GCD unit attached.
`timescale 1ns/1ps
module tb_gcd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*W-1:0] OPA, OPB;
  logic [NREQ-1:0]   ACK;
  logic [W-1:0]      RES_Y;
  logic              RES_ERR, BUSY;
  logic [IDW-1:0]    GNT_ID;
  logic              GCD_START;
  logic [W-1:0]      GCD_A, GCD_B, GCD_Y;
  logic              GCD_ERROR, GCD_DONE;
`ifdef GCD_TIMEOUT_EN
  logic              TIMEOUT;
`endif

  gcd_arbiter #(
    .NREQ(NREQ),
`ifdef GCD_TIMEOUT_EN
    .TIMEOUT_CYC(10),
`endif
    .W(W)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OPA(OPA), .OPB(OPB),
    .ACK(ACK), .RES_Y(RES_Y), .RES_ERR(RES_ERR), .BUSY(BUSY), .GNT_ID(GNT_ID),
    .GCD_START(GCD_START), .GCD_A(GCD_A), .GCD_B(GCD_B),
    .GCD_Y(GCD_Y), .GCD_ERROR(GCD_ERROR),
`ifdef GCD_TIMEOUT_EN
    .TIMEOUT(TIMEOUT),
`endif
    .GCD_DONE(GCD_DONE)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  int cyc = 0, ack_count = 0, start_count = 0, start_cyc = 0, last_ack_cyc = 0;

  typedef struct { int id; int y; int err; int tmo; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input int y, input int err, input int tmo);
    exp_t e;
    e.id = id; e.y = y; e.err = err; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    OPA[i*W +: W] = a;
    OPB[i*W +: W] = b;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_count < target && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    check(name, 32'(ack_count >= target), 1);
  endtask

  task automatic wait_start(input int budget, input string name);
    int n = 0;
    while (GCD_START !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, 32'(GCD_START === 1'b1), 1);
  endtask

  // Behavioural GCD: DONE stays high from the previous op for two WAIT cycles,
  // then falls, then rises with the new result.
  int         m_cnt;
  logic [W-1:0] m_a, m_b;
  bit         stub_done = 1'b0;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      m_cnt <= 0; GCD_DONE <= 1'b0; GCD_Y <= '0; GCD_ERROR <= 1'b0;
    end else if (GCD_START) begin
      m_cnt <= 6; m_a <= GCD_A; m_b <= GCD_B;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 5) GCD_DONE <= 1'b0;
      if (m_cnt == 1 && !stub_done) begin
        GCD_DONE  <= 1'b1;
        GCD_ERROR <= (m_a == 0 || m_b == 0);
        GCD_Y     <= (m_a == 0 || m_b == 0) ? '0 : gcd_f(m_a, m_b);
      end
    end
  end

  always @(negedge CLK) begin
    if (GCD_START === 1'b1) begin start_count++; start_cyc = cyc; end
    if (RST === 1'b0 && ACK != '0) begin
      ack_count++;
      last_ack_cyc = cyc;
      check("ack_onehot", 32'($onehot(ACK)), 1);
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(ACK), 0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_id", 32'(ACK), 32'(1) << mon_e.id);
        check("res_y", 32'(RES_Y), mon_e.y);
        check("res_err", 32'(RES_ERR), mon_e.err);
        check("busy_in_ack", 32'(BUSY), 1);
`ifdef GCD_TIMEOUT_EN
        check("timeout_flag", 32'(TIMEOUT), mon_e.tmo);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    RST = 1'b1; REQ = '0; OPA = '0; OPB = '0;
    repeat (3) @(negedge CLK);
    check("rst_ack", 32'(ACK), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_gnt", 32'(GNT_ID), 0);
    check("rst_start", 32'(GCD_START), 0);
    check("rst_a", 32'(GCD_A), 0);
    check("rst_b", 32'(GCD_B), 0);
    check("rst_y", 32'(RES_Y), 0);
    check("rst_err", 32'(RES_ERR), 0);
    RST = 1'b0;
    @(negedge CLK);

    // single request
    set_op(0, 21, 6);
    push_exp(0, 3, 0, 0);
    REQ[0] = 1'b1;
    wait_acks(1, 100, "t1_ack");
    REQ[0] = 1'b0;
    repeat (3) @(negedge CLK);
    check("t1_busy_after", 32'(BUSY), 0);
    check("t1_start_count", start_count, 1);

    // two simultaneous requests, pointer at 1
    set_op(1, 75, 60); set_op(3, 8, 29);
    push_exp(1, 15, 0, 0); push_exp(3, 1, 0, 0);
    REQ = 4'b1010;
    wait_acks(ack_count + 1, 100, "t2_ack1");
    REQ[1] = 1'b0;
    wait_acks(ack_count + 1, 100, "t2_ack3");
    REQ[3] = 1'b0;
    repeat (2) @(negedge CLK);

    // all four held: order 0,1,2,3,0
    set_op(0, 103, 103); set_op(1, 99, 11); set_op(2, 21, 6); set_op(3, 75, 60);
    push_exp(0, 103, 0, 0); push_exp(1, 11, 0, 0); push_exp(2, 3, 0, 0);
    push_exp(3, 15, 0, 0); push_exp(0, 103, 0, 0);
    base = ack_count;
    REQ = 4'b1111;
    wait_acks(base + 5, 300, "t3_acks");
    REQ = '0;
    repeat (2) @(negedge CLK);

    // error result and operand change after grant
    set_op(2, 7, 0);
    push_exp(2, 0, 1, 0);
    REQ[2] = 1'b1;
    wait_start(20, "t4_start");
    set_op(2, 99, 5);
    repeat (2) @(negedge CLK);
    check("t4_gcd_a_held", 32'(GCD_A), 7);
    check("t4_gcd_b_held", 32'(GCD_B), 0);
    wait_acks(ack_count + 1, 100, "t4_ack");
    REQ[2] = 1'b0;
    repeat (2) @(negedge CLK);

    // reset during WAIT aborts silently, then re-grant
    set_op(0, 21, 6);
    push_exp(0, 3, 0, 0);
    base = ack_count;
    REQ[0] = 1'b1;
    wait_start(20, "t5_start");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("t5_rst_ack", 32'(ACK), 0);
    check("t5_rst_busy", 32'(BUSY), 0);
    check("t5_rst_gnt", 32'(GNT_ID), 0);
    check("t5_rst_a", 32'(GCD_A), 0);
    check("t5_rst_err", 32'(RES_ERR), 0);
    check("t5_no_ack", ack_count, base);
    RST = 1'b0;
    wait_acks(base + 1, 100, "t5_ack");
    REQ[0] = 1'b0;
    repeat (4) @(negedge CLK);
    check("t5_single_ack", ack_count, base + 1);

`ifdef GCD_TIMEOUT_EN
    stub_done = 1'b1;
    set_op(1, 9, 3);
    push_exp(1, 0, 1, 1);
    REQ[1] = 1'b1;
    wait_acks(ack_count + 1, 100, "t6_ack");
    REQ[1] = 1'b0;
    check("t6_latency", last_ack_cyc - start_cyc, 10);
    stub_done = 1'b0;
    repeat (2) @(negedge CLK);
`endif

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
